// File: rtl/sonic_dma_pkg.sv
// Shared constants, field positions and channel state encoding for the DMA
// descriptor-header register file.
package sonic_dma_pkg;

    localparam logic [2:0] DW_CTRL    = 3'd0;
    localparam logic [2:0] DW_BASE_HI = 3'd1;
    localparam logic [2:0] DW_BASE_LO = 3'd2;
    localparam logic [2:0] DW_RC_LAST = 3'd3;
    localparam logic [2:0] DW_STATUS  = 3'd4;

    localparam logic [15:0] SOFT_RST_CODE = 16'hFFFF;

    localparam int BIT_MSI          = 17;
    localparam int BIT_EPLAST_ENA   = 18;
    localparam int MSI_NUM_LSB      = 20;
    localparam int MSI_TC_LSB       = 28;
    localparam int BIT_RC_LAST_SYNC = 31;

    localparam int ST_EP_LAST_LSB = 0;
    localparam int ST_BUSY        = 16;
    localparam int ST_ERR         = 17;
    localparam int ST_STATE_LSB   = 18;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2
    } chan_state_t;

endpackage

// File: rtl/sonic_dma_prg_chan.sv
// One DMA channel: header registers, run-state FSM, start pulse and status word.
// SONIC_DMA_PRG_BUSY_LOCK_EN: drop DW0-DW2 writes while running and flag them.
//
//   state   | meaning
//   INIT    | reset / unprogrammed, init output high
//   IDLE    | engine finished, waiting for next DW3 write
//   RUN     | engine started, waiting for busy to drop
module sonic_dma_prg_chan
    import sonic_dma_pkg::*;
(
    input  logic        clk_in,
    input  logic        rstn,
    input  logic        wr_en,
    input  logic [2:0]  dw_idx,
    input  logic [31:0] wr_data,
    input  logic        busy,
    input  logic [15:0] ep_last,
    output logic        start,
    output logic        init,
    output logic [15:0] size,
    output logic        msi,
    output logic        eplast_ena,
    output logic        rc_last_sync,
    output logic        rcadd_3dw,
    output logic [4:0]  msi_num,
    output logic [2:0]  msi_tc,
    output logic [63:0] base_rc,
    output logic [15:0] rc_last,
    output logic [31:0] rd_word
);

    chan_state_t state, state_nxt;
    logic [31:0] dw0, dw1, dw2, dw3;
    logic [15:0] size_m1;
    logic        rcadd_r, err, start_req, armed;
    logic        soft_rst, locked, lock_viol;
    logic        wr_dw0, wr_dw1, wr_dw2, wr_dw3;

    assign soft_rst = wr_en && (dw_idx == DW_CTRL) && (wr_data[15:0] == SOFT_RST_CODE);

`ifdef SONIC_DMA_PRG_BUSY_LOCK_EN
    assign locked = (state == ST_RUN);
`else
    assign locked = 1'b0;
`endif

    assign lock_viol = wr_en && !soft_rst && locked && (dw_idx <= DW_BASE_LO);
    assign wr_dw0    = wr_en && (dw_idx == DW_CTRL) && !soft_rst && !locked;
    assign wr_dw1    = wr_en && (dw_idx == DW_BASE_HI) && !locked;
    assign wr_dw2    = wr_en && (dw_idx == DW_BASE_LO) && !locked;
    assign wr_dw3    = wr_en && (dw_idx == DW_RC_LAST);

    // A new DW3 write outranks a busy fall seen in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (wr_dw3) state_nxt = ST_RUN;
            ST_IDLE: if (wr_dw3) state_nxt = ST_RUN;
            ST_RUN:  if (!wr_dw3 && armed && !busy) state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
        if (soft_rst) state_nxt = ST_INIT;
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_INIT;
            dw0       <= '0;
            dw1       <= '0;
            dw2       <= '0;
            dw3       <= '0;
            size_m1   <= '0;
            rcadd_r   <= 1'b0;
            err       <= 1'b0;
            start_req <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (soft_rst) begin
                dw0       <= '0;
                dw3       <= '0;
                size_m1   <= '0;
                err       <= 1'b0;
                start_req <= 1'b0;
                armed     <= 1'b0;
            end else begin
                if (wr_dw0) begin
                    dw0     <= wr_data;
                    size_m1 <= wr_data[15:0] - 16'd1;
                end
                if (wr_dw1) begin
                    dw1     <= wr_data;
                    rcadd_r <= (wr_data == 32'd0);
                end
                if (wr_dw2) dw2 <= wr_data;
                if (wr_dw3) dw3 <= wr_data;
                if (lock_viol) err <= 1'b1;
                start_req <= wr_dw3;
                // Busy is only trusted once the engine has seen the start pulse.
                if (wr_dw3)     armed <= 1'b0;
                else if (start) armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            start        <= 1'b0;
            init         <= 1'b1;
            size         <= '0;
            msi          <= 1'b0;
            eplast_ena   <= 1'b0;
            rc_last_sync <= 1'b0;
            rcadd_3dw    <= 1'b0;
            msi_num      <= '0;
            msi_tc       <= '0;
            base_rc      <= '0;
            rc_last      <= '0;
        end else begin
            start        <= start_req;
            init         <= (state == ST_INIT);
            size         <= size_m1;
            msi          <= dw0[BIT_MSI];
            eplast_ena   <= dw0[BIT_EPLAST_ENA];
            rc_last_sync <= dw0[BIT_RC_LAST_SYNC];
            rcadd_3dw    <= rcadd_r;
            msi_num      <= dw0[MSI_NUM_LSB +: 5];
            msi_tc       <= dw0[MSI_TC_LSB +: 3];
            base_rc      <= {dw1, dw2};
            rc_last      <= dw3[15:0];
        end
    end

    always_comb begin
        rd_word = '0;
        case (dw_idx)
            DW_CTRL:    rd_word = dw0;
            DW_BASE_HI: rd_word = dw1;
            DW_BASE_LO: rd_word = dw2;
            DW_RC_LAST: rd_word = dw3;
            DW_STATUS: begin
                rd_word[ST_EP_LAST_LSB +: 16] = ep_last;
                rd_word[ST_BUSY]              = busy;
                rd_word[ST_ERR]               = err;
                rd_word[ST_STATE_LSB +: 2]    = state;
            end
            default:    rd_word = '0;
        endcase
    end

endmodule

// File: rtl/sonic_dma_prg_regfile.sv
// Multi-channel DMA descriptor-header register file: input stage, channel
// decode, readback mux. Honours SONIC_DMA_PRG_BUSY_LOCK_EN inside each channel.
module sonic_dma_prg_regfile
    import sonic_dma_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 8
) (
    input  logic                  clk_in,
    input  logic                  rstn,
    input  logic                  dma_prg_wrena,
    input  logic [31:0]           dma_prg_wrdata,
    input  logic [ADDR_W-1:0]     dma_prg_addr,
    input  logic                  dma_prg_rdena,
    output logic [31:0]           dma_prg_rddata,
    output logic                  dma_prg_rdvalid,
    input  logic [NUM_CH-1:0]     dt_busy,
    input  logic [16*NUM_CH-1:0]  dt_ep_last,
    output logic [NUM_CH-1:0]     dt_start,
    output logic [NUM_CH-1:0]     init,
    output logic [16*NUM_CH-1:0]  dt_size,
    output logic [NUM_CH-1:0]     dt_msi,
    output logic [NUM_CH-1:0]     dt_eplast_ena,
    output logic [NUM_CH-1:0]     dt_rc_last_sync,
    output logic [NUM_CH-1:0]     dt_3dw_rcadd,
    output logic [5*NUM_CH-1:0]   app_msi_num,
    output logic [3*NUM_CH-1:0]   app_msi_tc,
    output logic [64*NUM_CH-1:0]  dt_base_rc,
    output logic [16*NUM_CH-1:0]  dt_rc_last
);

    localparam int CH_W = ADDR_W - 5;

    logic              s_wr, s_rd;
    logic [31:0]       s_data;
    logic [ADDR_W-3:0] s_addr;
    logic [CH_W-1:0]   s_ch;
    logic [2:0]        s_dw;
    logic [31:0]       rd_words [NUM_CH];
    logic [31:0]       rd_mux;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^dma_prg_addr[1:0];
    assign s_ch = s_addr[ADDR_W-3:3];
    assign s_dw = s_addr[2:0];

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            s_wr   <= 1'b0;
            s_rd   <= 1'b0;
            s_data <= '0;
            s_addr <= '0;
        end else begin
            s_wr   <= dma_prg_wrena;
            s_rd   <= dma_prg_rdena;
            s_data <= dma_prg_wrdata;
            s_addr <= dma_prg_addr[ADDR_W-1:2];
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sonic_dma_prg_chan u_chan (
            .clk_in       (clk_in),
            .rstn         (rstn),
            .wr_en        (s_wr && (int'(s_ch) == c)),
            .dw_idx       (s_dw),
            .wr_data      (s_data),
            .busy         (dt_busy[c]),
            .ep_last      (dt_ep_last[16*c +: 16]),
            .start        (dt_start[c]),
            .init         (init[c]),
            .size         (dt_size[16*c +: 16]),
            .msi          (dt_msi[c]),
            .eplast_ena   (dt_eplast_ena[c]),
            .rc_last_sync (dt_rc_last_sync[c]),
            .rcadd_3dw    (dt_3dw_rcadd[c]),
            .msi_num      (app_msi_num[5*c +: 5]),
            .msi_tc       (app_msi_tc[3*c +: 3]),
            .base_rc      (dt_base_rc[64*c +: 64]),
            .rc_last      (dt_rc_last[16*c +: 16]),
            .rd_word      (rd_words[c])
        );
    end

    // Unpopulated channel indices fall through and read as zero.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(s_ch) == c) rd_mux = rd_words[c];
        end
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            dma_prg_rddata  <= '0;
            dma_prg_rdvalid <= 1'b0;
        end else begin
            dma_prg_rddata  <= s_rd ? rd_mux : 32'd0;
            dma_prg_rdvalid <= s_rd;
        end
    end

endmodule

// File: doc/sonic_dma_prg_regfile.md
# sonic_dma_prg_regfile

Multi-channel DMA descriptor-header register file. It is the host-programmable front end of the chaining DMA engines: NUM_CH independent channels each hold size/MSI/control, descriptor-table base and RC-last registers, and each channel adds an explicit start pulse, a run-state FSM, a readable status word and busy write-protection. It sits between the BAR target write/read decode and the per-channel read/write DMA engines.

## Interface
Parameters:
- NUM_CH, 2, number of channels (1..8).
- ADDR_W, 8, byte address width; channel index = dma_prg_addr[ADDR_W-1:5]; DW index = dma_prg_addr[4:2].

Ports (per-channel outputs are flattened, channel c occupies slice c):
- clk_in  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- dma_prg_wrena  in  1  write strobe.
- dma_prg_wrdata  in  32  write data.
- dma_prg_addr  in  ADDR_W  byte address.
- dma_prg_rdena  in  1  read strobe.
- dma_prg_rddata  out  32  read data.
- dma_prg_rdvalid  out  1  read data valid.
- dt_busy  in  NUM_CH  engine busy, per channel.
- dt_ep_last  in  16*NUM_CH  engine's last completed descriptor.
- dt_start  out  NUM_CH  one-cycle start pulse.
- init  out  NUM_CH  channel in reset/unprogrammed state.
- dt_size  out  16*NUM_CH  DW0[15:0]-1.
- dt_msi, dt_eplast_ena, dt_rc_last_sync, dt_3dw_rcadd  out  NUM_CH each  DW0[17], DW0[18], DW0[31], (DW1==0).
- app_msi_num  out  5*NUM_CH  DW0[24:20]; app_msi_tc  out  3*NUM_CH  DW0[30:28].
- dt_base_rc  out  64*NUM_CH  {DW1,DW2}.
- dt_rc_last  out  16*NUM_CH  DW3[15:0].

## Operation
- Per-channel 32-byte window: DW0 control/size, DW1 base MSB, DW2 base LSB, DW3 RC-last, DW4 status (read-only: [15:0] dt_ep_last, [16] dt_busy, [17] write-while-busy error, [19:18] FSM state), DW5-7 read 0, writes ignored.
- Writes to channel index >= NUM_CH ignored; reads return 0 with rdvalid.
- Soft reset: DW0 write with wrdata[15:0]==16'hFFFF clears DW0, DW3, error flag; DW1/DW2 retained; FSM -> INIT.
- FSM per channel: INIT (init=1) -> RUN on DW3 write; RUN -> IDLE when dt_busy low for one sampled cycle after dt_start; IDLE -> RUN on DW3 write; any state -> INIT on soft reset, including mid-RUN (engine sees init high and aborts).
- Every DW3 write pulses dt_start, including in RUN (descriptor append/restart).
- Simultaneous dt_busy fall and DW3 write in RUN: stay RUN, pulse dt_start.
- dt_size wraps: DW0[15:0]=0 gives 16'hFFFF.
- Read of an address written in the same cycle returns the old value.

## Timing
- Write at edge N captured in input stage at N+1; register update at N+2; dt_* outputs, init, dt_start at N+3.
- Soft reset: clear at N+2 internally, init=1 and outputs cleared at N+3.
- Read: rdena at N -> rddata/rdvalid at N+2; rdvalid one cycle per rdena; back-to-back reads supported.
- Hard reset values: all outputs 0 (dt_base_rc 0, dt_3dw_rcadd 0) except init all ones; FSM INIT.

## Configuration
- SONIC_DMA_PRG_BUSY_LOCK_EN defined: DW0-DW2 writes to a channel in RUN are dropped and set status[17] (sticky until soft reset); soft-reset code still honoured.
- Undefined: all writes accepted in any state; status[17] reads 0.

## Structure
- sonic_dma_pkg: DW offset constants, soft-reset code 16'hFFFF, DW0 field bit positions, FSM state enum {INIT, IDLE, RUN}, status field positions.
- Sub-module sonic_dma_prg_chan: one channel's registers, FSM, start pulse and status word; top holds input stage, channel decode, readback mux, generate loop of NUM_CH instances.

## Test plan
- Hard reset, no traffic -> init=all ones, all other outputs 0, rddata 0.
- Ch1: DW0=0x8006_0010, DW1=0, DW2=0x1000_0000, DW3=5 -> dt_size[1]=0x000F, dt_msi=1, dt_eplast_ena=1, dt_rc_last_sync=1, dt_3dw_rcadd=1, dt_base_rc=0x1000_0000, dt_start[1] pulse at N+3, init[1]=0; ch0 unchanged.
- Ch0 RUN with dt_busy=1, write DW2=0xDEAD_BEEF -> with BUSY_LOCK_EN DW2 unchanged, status[17]=1; without, DW2 updated.
- Ch0 RUN, write DW0=0x0000_FFFF -> init[0]=1 at N+3, dt_size 0, DW1/DW2 readback unchanged, state INIT.
- dt_busy falls same cycle as DW3=7 write -> state stays RUN, dt_start pulses, dt_rc_last=7.
- Read ch index NUM_CH and DW6 -> rddata 0, rdvalid at N+2; read DW4 returns dt_ep_last and busy.
